// File: rtl/attn_score_pingpong_buf_pkg.sv
// Shared constants, bank-state encoding and count saturation for the attention score buffer.
package attn_score_pingpong_buf_pkg;

   localparam int unsigned TIME_STEPS        = 4;
   localparam int unsigned SYSTOLIC_UNIT_NUM = 16;
   localparam int unsigned FINAL_FMAPS_WIDTH = 64;
   localparam int unsigned IN_W              = 6;

   localparam int unsigned DEPTH   = FINAL_FMAPS_WIDTH * FINAL_FMAPS_WIDTH;
   localparam int unsigned SCORE_W = $clog2(2 * SYSTOLIC_UNIT_NUM);
   localparam int unsigned AW      = $clog2(DEPTH);
   localparam int unsigned RAW_W   = IN_W * TIME_STEPS;
   localparam int unsigned ENTRY_W = SCORE_W * TIME_STEPS;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef logic [1:0] bank_state_t;

   // Bit 1 set means the bank holds a complete score matrix (FULL or READING).
   localparam bank_state_t BANK_FREE    = 2'd0;
   localparam bank_state_t BANK_FILLING = 2'd1;
   localparam bank_state_t BANK_FULL    = 2'd2;
   localparam bank_state_t BANK_READING = 2'd3;

   // Clamp each per-step raw count to the largest value a stored count can hold.
   function automatic logic [ENTRY_W-1:0] sat_entry(input logic [RAW_W-1:0] raw);
      logic [ENTRY_W-1:0] res;
      logic [IN_W-1:0]    v;
      res = '0;
      for (int t = 0; t < int'(TIME_STEPS); t++) begin
         v = raw[IN_W*t +: IN_W];
         if (|v[IN_W-1:SCORE_W]) begin
            res[SCORE_W*t +: SCORE_W] = '1;
         end else begin
            res[SCORE_W*t +: SCORE_W] = v[SCORE_W-1:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/attn_score_bank_ram.sv
// One score bank: simple dual-port RAM with a registered read port.
// The array itself is never cleared; only the read register is reset.
module attn_score_bank_ram
   import attn_score_pingpong_buf_pkg::*;
(
   input  logic               s_clk,
   input  logic               s_rst,
   input  logic               wr_en_i,
   input  logic [AW-1:0]      wr_addr_i,
   input  logic [ENTRY_W-1:0] wr_data_i,
   input  logic [AW-1:0]      rd_addr_i,
   output logic [ENTRY_W-1:0] rd_data_o
);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [ENTRY_W-1:0] rd_data_q;

   // Storage write port.
   always_ff @(posedge s_clk) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   // Registered read so data appears one cycle after the address.
   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/attn_score_pingpong_buf.sv
// Ping-pong buffer for spiking attention scores. The upstream stage fills one bank
// sequentially while the downstream reader consumes the other; a Done pulse frees it.
module attn_score_pingpong_buf
   import attn_score_pingpong_buf_pkg::*;
(
   input  logic               s_clk,
   input  logic               s_rst,
   input  logic               i_wr_valid,
   input  logic [RAW_W-1:0]   i_wr_data,
   output logic               o_wr_ready,
   output logic               o_AttnRAM_Empty,
   input  logic [AW-1:0]      i_AttnRam_rd_addr,
   output logic [ENTRY_W-1:0] o_AttnRAM_data,
   input  logic               i_AttnRam_Done,
   output logic [1:0]         o_bank_full_cnt,
   output logic               o_err
);

   localparam logic [AW:0] STALL_MAX = (AW+1)'(DEPTH);

   bank_state_t [1:0] bank_st_q, bank_st_d;
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic              rd_sel_q;
   logic [AW-1:0]     wr_addr_q, wr_addr_d;
   logic [AW:0]       stall_cnt_q, stall_cnt_d;
   logic [1:0]        full_cnt_q, full_cnt_d;
   logic              err_q, err_d;

   logic               wr_acc, wr_last, any_reading, done_ok, stall;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] rd_data [2];

   assign o_wr_ready  = (bank_st_q[wr_bank_q] == BANK_FREE) ||
                        (bank_st_q[wr_bank_q] == BANK_FILLING);
   assign wr_acc      = i_wr_valid && o_wr_ready;
   assign wr_last     = wr_acc && (wr_addr_q == LAST_ADDR);
   assign any_reading = (bank_st_q[0] == BANK_READING) || (bank_st_q[1] == BANK_READING);
   assign done_ok     = i_AttnRam_Done && any_reading;
   assign stall       = i_wr_valid && !o_wr_ready;
   assign wr_entry    = sat_entry(i_wr_data);

   // The read bank always holds the next complete matrix, so Empty only needs to
   // look at it; a bank that just turned FULL is already visible to the reader.
   assign o_AttnRAM_Empty = !bank_st_q[rd_bank_q][1];
   assign o_AttnRAM_data  = rd_data[rd_sel_q];
   assign o_bank_full_cnt = full_cnt_q;
   assign o_err           = err_q;

   // Bank state transitions, pointer updates, stall watchdog and error flag.
   always_comb begin
      full_cnt_d = '0;
      for (int b = 0; b < 2; b++) begin
         bank_st_d[b] = bank_st_q[b];
         if (wr_acc && (wr_bank_q == 1'(b))) begin
            bank_st_d[b] = wr_last ? BANK_FULL : BANK_FILLING;
         end else if ((bank_st_q[b] == BANK_FULL) && (rd_bank_q == 1'(b)) && !any_reading) begin
            bank_st_d[b] = BANK_READING;
         end else if (done_ok && (bank_st_q[b] == BANK_READING)) begin
            bank_st_d[b] = BANK_FREE;
         end
         if (bank_st_d[b][1]) begin
            full_cnt_d = full_cnt_d + 2'd1;
         end
      end

      wr_addr_d = wr_acc ? wr_addr_q + AW'(1) : wr_addr_q;
      wr_bank_d = wr_bank_q ^ wr_last;
      rd_bank_d = rd_bank_q ^ done_ok;

      stall_cnt_d = '0;
      if (stall) begin
         stall_cnt_d = (stall_cnt_q == STALL_MAX) ? STALL_MAX : stall_cnt_q + (AW+1)'(1);
      end

      err_d = err_q || (i_AttnRam_Done && !any_reading) ||
              (stall && (stall_cnt_q == STALL_MAX));
   end

   // Control state registers.
   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         bank_st_q   <= {BANK_FREE, BANK_FREE};
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         rd_sel_q    <= 1'b0;
         wr_addr_q   <= '0;
         stall_cnt_q <= '0;
         full_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         bank_st_q   <= bank_st_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         rd_sel_q    <= rd_bank_q;
         wr_addr_q   <= wr_addr_d;
         stall_cnt_q <= stall_cnt_d;
         full_cnt_q  <= full_cnt_d;
         err_q       <= err_d;
      end
   end

   // Both banks see every read address; the bank selected at address time is output.
   for (genvar b = 0; b < 2; b++) begin : g_bank
      attn_score_bank_ram u_ram (
         .s_clk     (s_clk),
         .s_rst     (s_rst),
         .wr_en_i   (wr_acc && (wr_bank_q == 1'(b))),
         .wr_addr_i (wr_addr_q),
         .wr_data_i (wr_entry),
         .rd_addr_i (i_AttnRam_rd_addr),
         .rd_data_o (rd_data[b])
      );
   end

endmodule

// File: tb/tb_attn_score_pingpong_buf.sv
// Scoreboard bench: reads push expected data, a monitor pops and compares the
// registered read data; status outputs are checked directly at the falling edge.
module tb_attn_score_pingpong_buf;
   import attn_score_pingpong_buf_pkg::*;

   logic               s_clk = 1'b0;
   logic               s_rst;
   logic               i_wr_valid;
   logic [RAW_W-1:0]   i_wr_data;
   logic               o_wr_ready;
   logic               o_AttnRAM_Empty;
   logic [AW-1:0]      i_AttnRam_rd_addr;
   logic [ENTRY_W-1:0] o_AttnRAM_data;
   logic               i_AttnRam_Done;
   logic [1:0]         o_bank_full_cnt;
   logic               o_err;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      string              name;
      logic [ENTRY_W-1:0] exp;
   } rd_exp_t;

   rd_exp_t sb_q[$];
   logic    rd_issue = 1'b0;
   logic    rd_vld   = 1'b0;

   always #5 s_clk = ~s_clk;

   attn_score_pingpong_buf dut (
      .s_clk             (s_clk),
      .s_rst             (s_rst),
      .i_wr_valid        (i_wr_valid),
      .i_wr_data         (i_wr_data),
      .o_wr_ready        (o_wr_ready),
      .o_AttnRAM_Empty   (o_AttnRAM_Empty),
      .i_AttnRam_rd_addr (i_AttnRam_rd_addr),
      .o_AttnRAM_data    (o_AttnRAM_data),
      .i_AttnRam_Done    (i_AttnRam_Done),
      .o_bank_full_cnt   (o_bank_full_cnt),
      .o_err             (o_err)
   );

   // Raw per-step counts for entry a; concatenation order is {t3, t2, t1, t0}.
   function automatic logic [RAW_W-1:0] raw_of(input int off, input int a);
      logic [IN_W-1:0] v;
      if (a == 100) return {6'd0, 6'd31, 6'd32, 6'd40};
      if (a == 101) return {6'd1, 6'd63, 6'd33, 6'd17};
      v = IN_W'((a + off) % 32);
      return {v, v, v, v};
   endfunction

   localparam logic [ENTRY_W-1:0] EXP_100 = {5'd0, 5'd31, 5'd31, 5'd31};
   localparam logic [ENTRY_W-1:0] EXP_101 = {5'd1, 5'd31, 5'd31, 5'd17};

   task automatic tick();
      @(posedge s_clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", nm, got, want);
      end
   endtask

   task automatic status(input string nm, input logic rdy, input logic emp,
                         input logic [1:0] cnt, input logic err);
      chk({nm, "_ready"}, 32'(o_wr_ready), 32'(rdy));
      chk({nm, "_empty"}, 32'(o_AttnRAM_Empty), 32'(emp));
      chk({nm, "_cnt"}, 32'(o_bank_full_cnt), 32'(cnt));
      chk({nm, "_err"}, 32'(o_err), 32'(err));
   endtask

   task automatic fill(input int off, input int n);
      for (int a = 0; a < n; a++) begin
         i_wr_valid = 1'b1;
         i_wr_data  = raw_of(off, a);
         tick();
      end
      i_wr_valid = 1'b0;
      i_wr_data  = '0;
   endtask

   task automatic rd(input string nm, input int a, input logic [ENTRY_W-1:0] e);
      rd_exp_t item;
      item.name = nm;
      item.exp  = e;
      sb_q.push_back(item);
      i_AttnRam_rd_addr = AW'(a);
      rd_issue = 1'b1;
      tick();
      rd_issue = 1'b0;
   endtask

   task automatic done_pulse();
      i_AttnRam_Done = 1'b1;
      tick();
      i_AttnRam_Done = 1'b0;
   endtask

   // Read data becomes valid one cycle after the address was issued.
   always @(posedge s_clk) rd_vld <= rd_issue;

   // Monitor: pop the oldest expected read and compare against the DUT.
   always @(negedge s_clk) begin
      rd_exp_t item;
      if (rd_vld) begin
         n_vec++;
         if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_underflow: got %0h, want no data", o_AttnRAM_data);
         end else begin
            item = sb_q.pop_front();
            if (o_AttnRAM_data !== item.exp) begin
               n_bad++;
               $display("FAIL %s: got %h, want %h", item.name, o_AttnRAM_data, item.exp);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   initial begin
      s_rst             = 1'b1;
      i_wr_valid        = 1'b0;
      i_wr_data         = '0;
      i_AttnRam_rd_addr = '0;
      i_AttnRam_Done    = 1'b0;

      @(negedge s_clk);
      status("reset", 1'b1, 1'b1, 2'd0, 1'b0);
      chk("reset_data", 32'(o_AttnRAM_data), 32'd0);
      repeat (2) @(posedge s_clk);
      #1 s_rst = 1'b0;

      // Bank 0: counts = addr mod 32, plus two saturation entries.
      fill(0, DEPTH);
      tick();
      @(negedge s_clk);
      status("fill0", 1'b1, 1'b0, 2'd1, 1'b0);
      rd("b0_a37", 37, {4{5'd5}});
      rd("b0_sat100", 100, EXP_100);
      rd("b0_sat101", 101, EXP_101);
      rd("b0_a4095", 4095, {4{5'd31}});
      rd("b0_a0", 0, '0);

      // Bank 1 fills while bank 0 is being read.
      fill(3, DEPTH);
      @(negedge s_clk);
      status("fill1", 1'b0, 1'b0, 2'd2, 1'b0);

      // Writes while not ready must be dropped.
      i_wr_valid = 1'b1;
      i_wr_data  = {4{6'd9}};
      repeat (3) tick();
      i_wr_valid = 1'b0;
      rd("drop_a0", 0, '0);
      rd("drop_a37", 37, {4{5'd5}});

      // Done on bank 0 hands over to the already-full bank 1.
      done_pulse();
      @(negedge s_clk);
      status("done0", 1'b1, 1'b0, 2'd1, 1'b0);
      rd("b1_a37", 37, {4{5'd8}});
      rd("b1_a4095", 4095, {4{5'd2}});
      rd("b1_sat100", 100, EXP_100);

      // Last write of bank 0 coincides with Done on bank 1.
      fill(9, DEPTH - 1);
      i_wr_valid     = 1'b1;
      i_wr_data      = raw_of(9, DEPTH - 1);
      i_AttnRam_Done = 1'b1;
      tick();
      i_wr_valid     = 1'b0;
      i_AttnRam_Done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge s_clk);
         chk("overlap_empty", 32'(o_AttnRAM_Empty), 32'd0);
         tick();
      end
      @(negedge s_clk);
      status("overlap", 1'b1, 1'b0, 2'd1, 1'b0);
      rd("b0p2_a37", 37, {4{5'd14}});
      rd("b0p2_a4095", 4095, {4{5'd8}});

      // Free bank 0, then a spurious Done with both banks free.
      done_pulse();
      @(negedge s_clk);
      status("freed", 1'b1, 1'b1, 2'd0, 1'b0);
      done_pulse();
      @(negedge s_clk);
      status("spurious", 1'b1, 1'b1, 2'd0, 1'b1);
      repeat (5) tick();
      @(negedge s_clk);
      status("sticky", 1'b1, 1'b1, 2'd0, 1'b1);

      // Fill bank 1, read, then asynchronous reset between clock edges.
      fill(17, DEPTH);
      tick();
      @(negedge s_clk);
      status("fill1b", 1'b1, 1'b0, 2'd1, 1'b1);
      rd("b1b_a2000", 2000, {4{5'd1}});
      @(posedge s_clk);
      #3 s_rst = 1'b1;
      #1;
      status("async_rst", 1'b1, 1'b1, 2'd0, 1'b0);
      chk("async_rst_data", 32'(o_AttnRAM_data), 32'd0);
      repeat (2) @(posedge s_clk);
      #1 s_rst = 1'b0;

      // Fresh fill after reset lands in bank 0.
      fill(21, DEPTH);
      tick();
      @(negedge s_clk);
      status("refill", 1'b1, 1'b0, 2'd1, 1'b0);
      rd("re_a37", 37, {4{5'd26}});
      rd("re_sat100", 100, EXP_100);

      // Fill bank 1, then stall: error only after more than DEPTH stalled cycles.
      fill(5, DEPTH);
      @(negedge s_clk);
      status("both_full", 1'b0, 1'b0, 2'd2, 1'b0);
      i_wr_valid = 1'b1;
      repeat (DEPTH) tick();
      @(negedge s_clk);
      chk("stall_depth_err", 32'(o_err), 32'd0);
      tick();
      @(negedge s_clk);
      chk("stall_over_err", 32'(o_err), 32'd1);
      i_wr_valid = 1'b0;

      tick();
      chk("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
